// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipeline applying one of eight bitwise gates across NUM_IN operands.
// Optional completed-transfer counter is built when LOGIC_GATE_PIPE_STATS_EN is defined.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [2:0]              out_op,
  output logic [CNT_W-1:0]        done_cnt
);

  generate
    if (NUM_IN < 2 || WIDTH < 1) begin : g_param_check
      $error("logic_gate_pipe: NUM_IN must be >= 2 and WIDTH >= 1");
    end
  endgenerate

  logic                    s1_valid;
  logic [NUM_IN*WIDTH-1:0] s1_data;
  logic [2:0]              s1_op;
  logic                    s2_free;
  logic                    s1_adv;
  logic                    in_fire;
  logic [WIDTH-1:0]        and_r;
  logic [WIDTH-1:0]        or_r;
  logic [WIDTH-1:0]        xor_r;
  logic [WIDTH-1:0]        result;

  // in_ready depends only on pipeline state and out_ready, never on in_valid
  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_op    <= 3'd0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_op    <= in_op;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Reduce all operands once per gate family; the op then picks or inverts one
  always_comb begin
    and_r  = '1;
    or_r   = '0;
    xor_r  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      and_r = and_r & s1_data[k*WIDTH +: WIDTH];
      or_r  = or_r  | s1_data[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ s1_data[k*WIDTH +: WIDTH];
    end
    result = '0;
    case (s1_op)
      3'd0: result = and_r;
      3'd1: result = or_r;
      3'd2: result = ~and_r;
      3'd3: result = ~or_r;
      3'd4: result = xor_r;
      3'd5: result = ~xor_r;
      3'd6: result = ~s1_data[WIDTH-1:0];
      3'd7: result = s1_data[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= 3'd0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_op    <= s1_op;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LOGIC_GATE_PIPE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] cnt;

  // Saturating count of output handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (out_valid && out_ready && (cnt != '1)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign done_cnt = cnt;
`else
  assign done_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: randomized and directed stimulus against a per-bit
// population-count reference model, plus a WIDTH=1/NUM_IN=2 instance for the NOR corner.
module tb_logic_gate_pipe;

  localparam int W = 8;
  localparam int N = 4;
  localparam int CW = 4;
`ifdef LOGIC_GATE_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] in_data;
  logic [2:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    out_op;
  logic [CW-1:0] done_cnt;

  logic          e_in_valid;
  logic          e_in_ready;
  logic [1:0]    e_in_data;
  logic [2:0]    e_in_op;
  logic          e_out_valid;
  logic [0:0]    e_out_data;
  logic [2:0]    e_out_op;
  logic [CW-1:0] e_done_cnt;

  logic_gate_pipe #(.WIDTH(W), .NUM_IN(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_op(out_op),
    .done_cnt(done_cnt)
  );

  logic_gate_pipe #(.WIDTH(1), .NUM_IN(2), .CNT_W(CW)) dut_edge (
    .clk(clk), .rst(rst),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data), .in_op(e_in_op),
    .out_valid(e_out_valid), .out_ready(1'b1), .out_data(e_out_data), .out_op(e_out_op),
    .done_cnt(e_done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   op;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int unsigned model_cnt = 0;
  bit          prev_stall = 0;
  logic [W-1:0] held_data;
  logic [2:0]  held_op;

  always @(posedge clk) cyc <= cyc + 1;

  // Each result bit is decided by how many operands have that bit set
  function automatic int unsigned ref_gate(input int unsigned ops[8], input int n,
                                           input int op, input int w);
    int unsigned r;
    int ones;
    bit v;
    bit b0;
    r = 0;
    for (int b = 0; b < w; b++) begin
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'((ops[i] >> b) & 1);
      b0 = ((ops[0] >> b) & 1) == 1;
      case (op)
        0: v = (ones == n);
        1: v = (ones > 0);
        2: v = (ones != n);
        3: v = (ones == 0);
        4: v = (ones % 2) == 1;
        5: v = (ones % 2) == 0;
        6: v = !b0;
        default: v = b0;
      endcase
      if (v) r |= (32'd1 << b);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushExpected(input logic [N*W-1:0] data, input logic [2:0] op, input bit lat);
    int unsigned ops[8];
    exp_t e;
    for (int k = 0; k < 8; k++) ops[k] = 0;
    for (int k = 0; k < N; k++) ops[k] = int'(data[k*W +: W]);
    e.data = W'(ref_gate(ops, N, int'(op), W));
    e.op   = op;
    e.acc  = cyc;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge
  task automatic applyStimulus(input logic [N*W-1:0] data, input logic [2:0] op,
                               input bit lat, output int stalls);
    bit done;
    done = 0;
    stalls = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_op    = op;
    while (!done && stalls < 200) begin
      @(negedge clk);
      if (in_ready) begin
        pushExpected(data, op, lat);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_data  = N*W'($urandom);
    in_op    = 3'($urandom);
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checkOutput("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold stability and the counter
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 0;
      model_cnt  = 0;
    end else begin
      checkOutput("done_cnt", done_cnt, STATS ? model_cnt : 0);
      if (prev_stall && out_valid) begin
        checkOutput("hold_data", out_data, held_data);
        checkOutput("hold_op", out_op, held_op);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_op", out_op, e.op);
          if (e.lat) checkOutput("latency", cyc - e.acc, 2);
        end
        if (model_cnt < (2**CW - 1)) model_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
      held_op    = out_op;
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int stalls;
    int idx;
    logic [N*W-1:0] bp_data[4];
    logic [1:0] ab;
    int unsigned eops[8];

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_op = 3'd0; out_ready = 1'b1;
    e_in_valid = 1'b0; e_in_data = 2'd0; e_in_op = 3'd0;
    #3;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_op", out_op, 0);
    checkOutput("rst_done_cnt", done_cnt, 0);
    #9 rst = 1'b0;
    #1 checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    $display("[TB] truth sweep");
    for (int op = 0; op < 8; op++) begin
      applyStimulus(32'hFFAACCF0, 3'(op), 1'b1, stalls);
    end
    waitDrain();

    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(N*W'($urandom), 3'($urandom), 1'b1, stalls);
      checkOutput("stream_no_stall", stalls, 0);
    end
    waitDrain();

    $display("[TB] backpressure");
    for (int i = 0; i < 4; i++) bp_data[i] = N*W'($urandom);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = bp_data[idx];
      in_op    = 3'd4;
      @(negedge clk);
      if (in_ready) begin
        pushExpected(bp_data[idx], 3'd4, 1'b0);
        idx++;
      end
      @(posedge clk); #1;
    end
    checkOutput("bp_accepted", idx, 2);
    checkOutput("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    while (idx < 4) begin
      applyStimulus(bp_data[idx], 3'd4, 1'b0, stalls);
      idx++;
    end
    waitDrain();

    $display("[TB] random backpressure");
    fork
      begin
        repeat (150) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          applyStimulus(N*W'($urandom), 3'($urandom), 1'b0, stalls);
        end
      end
    join
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] reset mid-flight");
    out_ready = 1'b0;
    applyStimulus(N*W'($urandom), 3'd1, 1'b0, stalls);
    applyStimulus(N*W'($urandom), 3'd2, 1'b0, stalls);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_done_cnt", done_cnt, 0);
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_rst_no_output", out_valid, 0);
    end
    @(posedge clk); #1;

    $display("[TB] counter saturation");
    for (int i = 0; i < 20; i++) applyStimulus(N*W'($urandom), 3'($urandom), 1'b1, stalls);
    waitDrain();
    checkOutput("done_cnt_final", done_cnt, STATS ? 15 : 0);

    $display("[TB] WIDTH=1 NUM_IN=2 NOR");
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      for (int k = 0; k < 8; k++) eops[k] = 0;
      eops[0] = ab[0];
      eops[1] = ab[1];
      @(posedge clk); #1;
      e_in_valid = 1'b1; e_in_data = ab; e_in_op = 3'd3;
      @(posedge clk); #1;
      e_in_valid = 1'b0; e_in_op = 3'd7;
      @(posedge clk);
      @(negedge clk);
      checkOutput("edge_valid", e_out_valid, 1);
      checkOutput("edge_nor", e_out_data, ref_gate(eops, 2, 3, 1));
      checkOutput("edge_op", e_out_op, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
